interrupt_controller: RTL

//   Receiving end of the hardware-interrupt request path. Collects rising-edge

---
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/interrupt_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and its environment: peripheral
// request lines, the register port and the CPU interrupt handshake.
interface interrupt_controller_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irqIn;
  logic               regWrite;
  logic [1:0]         regAddr;
  logic [15:0]        regWdata;
  logic [15:0]        regRdata;
  logic               intSignal;
  logic [3:0]         intIndex;
  logic               intAck;
  logic               intDone;
  logic               busy;

  // Environment side: peripherals, register bus master and CPU.
  modport master (
    output irqIn, regWrite, regAddr, regWdata, intAck, intDone,
    input  regRdata, intSignal, intIndex, busy
  );

  // Controller side.
  modport slave (
    input  irqIn, regWrite, regAddr, regWdata, intAck, intDone,
    output regRdata, intSignal, intIndex, busy
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects peripheral requests into a pending
// register, applies mask and fixed priority (bit 0 highest), and presents
// one interrupt at a time to the CPU through a request/ack/done handshake.
module interrupt_controller #(
  parameter int          NUM_SRC    = 4,
  parameter logic [3:0]  INDEX_BASE = 4'h1,
  parameter logic [15:0] MASK_RST   = 16'h000F
) (
  input logic                  clk,
  input logic                  rst,
  interrupt_controller_if.slave bus
);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SOFTSET = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irqPrev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic               primed;
  logic [3:0]         activeSrc;
  logic               intSignalR;
  logic [3:0]         intIndexR;
  logic               busyR;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] setBits;
  logic [NUM_SRC-1:0] clrBits;
  logic [NUM_SRC-1:0] activeOne;
  logic [NUM_SRC-1:0] reqVec;
  logic [3:0]         lowIdx;
  logic               ackTaken;
  logic               wrMask;
  logic               wrPending;
  logic               wrSoftset;

  assign wrMask    = bus.regWrite && (bus.regAddr == ADDR_MASK);
  assign wrPending = bus.regWrite && (bus.regAddr == ADDR_PENDING);
  assign wrSoftset = bus.regWrite && (bus.regAddr == ADDR_SOFTSET);
  assign ackTaken  = (state == REQUEST) && bus.intAck;

  // The first cycle after reset only records the request lines as a
  // baseline, so a line already high at release is not seen as an edge.
  assign edges   = primed ? (bus.irqIn & ~irqPrev) : '0;
  assign reqVec  = pending & mask;
  assign setBits = edges | (wrSoftset ? bus.regWdata[NUM_SRC-1:0] : '0);
  assign clrBits = (wrPending ? bus.regWdata[NUM_SRC-1:0] : '0) |
                   (ackTaken ? activeOne : '0);

  // One-hot of the source being serviced and lowest-index pending request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    activeOne = '0;
    lowIdx    = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      activeOne[i] = (activeSrc == 4'(i));
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (reqVec[i]) lowIdx = 4'(i);
    end
  end

  // Request capture: edge history, pending (set wins over clear) and mask.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      irqPrev <= '0;
      primed  <= 1'b0;
      pending <= '0;
      mask    <= MASK_RST[NUM_SRC-1:0];
    end else begin
      irqPrev <= bus.irqIn;
      primed  <= 1'b1;
      pending <= (pending & ~clrBits) | setBits;
      if (wrMask) mask <= bus.regWdata[NUM_SRC-1:0];
    end
  end

  // Handshake FSM with registered intSignal/intIndex/busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      activeSrc  <= 4'd0;
      intSignalR <= 1'b0;
      intIndexR  <= 4'd0;
      busyR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|reqVec) begin
            state      <= REQUEST;
            activeSrc  <= lowIdx;
            intIndexR  <= INDEX_BASE + lowIdx;
            intSignalR <= 1'b1;
            busyR      <= 1'b1;
          end
        end
        REQUEST: begin
          // Ack takes precedence; a simultaneous done is ignored here.
          if (bus.intAck) begin
            state      <= SERVICE;
            intSignalR <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.intDone) begin
            state <= IDLE;
            busyR <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          intSignalR <= 1'b0;
          busyR      <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read port.
  always_comb begin
    bus.regRdata = 16'h0000;
    case (bus.regAddr)
      ADDR_MASK:    bus.regRdata = 16'(mask);
      ADDR_PENDING: bus.regRdata = 16'(pending);
      ADDR_STATUS:  bus.regRdata = {busyR, 2'(state), 9'b0, activeSrc};
      ADDR_SOFTSET: bus.regRdata = 16'h0000;
      default:      bus.regRdata = 16'h0000;
    endcase
  end

  assign bus.intSignal = intSignalR;
  assign bus.intIndex  = intIndexR;
  assign bus.busy      = busyR;

endmodule
